ro_edge_counter: RTL and testbench
==================================

// Module: ro_edge_counter
// PURPOSE
//  Measurement end of the RO-PUF oscillator select path: drives the 3-bit select
//  into the 8:1 oscillator multiplexer and counts rising edges on the muxed
//  oscillator output over a programmable gate window of clk cycles.
//  Sits between the challenge scrambler/controller and the response comparator.
//  One measurement per start request; the result is held until the next start.
// PARAMETERS
//  CNT_W       16  width of edge count result
//  WIN_W       16  width of gate-window length input
//  SETTLE_CYC  4   clk cycles between select change and window open (>=SYNC_STAGES+1)
//  SYNC_STAGES 2   flip-flop synchronizer depth on ro_in (>=2)
// PORTS
//  clk       in   1      system clock, single domain
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request a measurement; sampled only in IDLE
//  sel_in    in   3      oscillator index for this measurement
//  window    in   WIN_W  gate length in clk cycles; sampled with start
//  ro_in     in   1      muxed oscillator output (asynchronous to clk)
//  mux_sel   out  3      select driven to the 8:1 oscillator mux
//  busy      out  1      high from cycle after accepted start until done
//  done      out  1      one-cycle pulse: count valid
//  count     out  CNT_W  rising edges seen in the window
//  sat       out  1      count saturated at all-ones
// BEHAVIOUR
//  Reset: state IDLE; mux_sel=0, busy=0, done=0, count=0, sat=0; synchronizer
//   and edge-detect flops cleared. Reset mid-measurement aborts, no done pulse.
//  ro_in passes through SYNC_STAGES flops then one edge-detect flop; rise = sync
//   high AND previous low. Only synchronized rises are counted; no other use of ro_in.
//  FSM: IDLE -> SETTLE -> COUNT -> DONE -> IDLE.
//   IDLE: start=1 at edge t -> at t+1 mux_sel=sel_in, window latched, busy=1,
//    internal count cleared, sat cleared, state SETTLE. start while busy ignored.
//   SETTLE: exactly SETTLE_CYC cycles; rises ignored (flush of old oscillator).
//   COUNT: exactly window latched cycles; each cycle with a rise increments count.
//    window=0: COUNT skipped, SETTLE goes straight to DONE, count=0.
//   DONE: one cycle; done=1, busy=0 that cycle; next state IDLE.
//  Latency start-to-done = 1 + SETTLE_CYC + window cycles (done high in cycle
//   index 1+SETTLE_CYC+window after the start edge).
//  count saturates at 2^CNT_W-1; further rises set/keep sat=1, count unchanged.
//  count and sat: stable from done until next accepted start; cleared at that start.
//  mux_sel holds its value after DONE until the next accepted start.
//  start coincident with done (DONE state) is ignored; must be reissued in IDLE.
//  window counter is WIN_W wide; window=all-ones is legal, no wrap.
// TESTING
//  Reset, idle 10 cycles -> mux_sel=0, busy=0, done=0, count=0, sat=0.
//  sel_in=5, window=100, ro_in toggling every 5 clk (period 10) -> mux_sel=5 one
//   cycle after start; done exactly 1+4+100 cycles after start; count=10 (+/-1).
//  window=0, sel_in=3 -> done 5 cycles after start; count=0; mux_sel=3.
//  CNT_W=4, window=200, ro_in period 4 clk -> count=15, sat=1 at done.
//  start pulsed again during COUNT, and on done cycle -> ignored; single done pulse.
//  rst asserted mid-COUNT -> next cycle all outputs at reset values, no done pulse;
//   fresh start afterwards measures correctly.

Source files
------------

// File: rtl/ro_edge_counter.sv
// RO-PUF measurement end: drives the oscillator mux select and counts
// synchronized rising edges of the selected oscillator over a gate window.
module ro_edge_counter #(
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SETTLE_CYC  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       sel_in,
   input  logic [WIN_W-1:0] window,
   input  logic             ro_in,
   output logic [2:0]       mux_sel,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_rise;

   logic [SET_W-1:0]       r_set_cnt;
   logic [WIN_W-1:0]       r_win_cnt;
   logic [2:0]             r_mux_sel;
   logic [CNT_W-1:0]       r_count;
   logic                   r_sat;

   logic                   w_accept;
   logic                   w_set_last;
   logic                   w_win_zero;
   logic                   w_win_last;
   logic                   w_cnt_full;
   logic                   w_busy;
   logic                   w_done;

   // ro_in is asynchronous; only the synchronized copy is ever used
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ro_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_accept   = (r_state == S_IDLE) & start;
   assign w_set_last = (r_set_cnt == '0);
   assign w_win_zero = (r_win_cnt == '0);
   assign w_win_last = (r_win_cnt == WIN_W'(1));
   assign w_cnt_full = (r_count == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_SETTLE;
            end
         end
         S_SETTLE: begin
            w_busy = 1'b1;
            if (w_set_last) begin
               w_next = w_win_zero ? S_DONE : S_COUNT;
            end
         end
         S_COUNT: begin
            w_busy = 1'b1;
            if (w_win_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Window counter counts down from the latched length, so all-ones never wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mux_sel <= 3'd0;
         r_win_cnt <= '0;
         r_set_cnt <= '0;
         r_count   <= '0;
         r_sat     <= 1'b0;
      end else if (w_accept) begin
         r_mux_sel <= sel_in;
         r_win_cnt <= window;
         r_set_cnt <= SET_W'(SETTLE_CYC - 1);
         r_count   <= '0;
         r_sat     <= 1'b0;
      end else begin
         if ((r_state == S_SETTLE) && !w_set_last) begin
            r_set_cnt <= r_set_cnt - SET_W'(1);
         end
         if (r_state == S_COUNT) begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
            if (w_rise) begin
               if (w_cnt_full) begin
                  r_sat <= 1'b1;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
         end
      end
   end

   assign mux_sel = r_mux_sel;
   assign busy    = w_busy;
   assign done    = w_done;
   assign count   = r_count;
   assign sat     = r_sat;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Bench for ro_edge_counter: scoreboarded measurements on a 16-bit and a
// 4-bit counter instance, plus reset, ignored-start and abort scenarios.
`timescale 1ns/1ps
module tb_ro_edge_counter;

   localparam int SETTLE = 4;

   typedef struct {
      int         lo;
      int         hi;
      bit         esat;
      logic [2:0] sel;
      int         lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start_a;
   logic        start_b;
   logic [2:0]  sel_in;
   logic [15:0] window;
   logic        ro_in;

   logic [2:0]  mux_sel_a;
   logic        busy_a;
   logic        done_a;
   logic [15:0] count_a;
   logic        sat_a;

   logic [2:0]  mux_sel_b;
   logic        busy_b;
   logic        done_b;
   logic [3:0]  count_b;
   logic        sat_b;

   bit          cur_b;
   logic [2:0]  t_mux;
   logic        t_busy;
   logic        t_done;
   logic [15:0] t_count;
   logic        t_sat;

   int          chk;
   int          err;
   exp_t        sbq[$];

   ro_edge_counter u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a),
      .sel_in  (sel_in),
      .window  (window),
      .ro_in   (ro_in),
      .mux_sel (mux_sel_a),
      .busy    (busy_a),
      .done    (done_a),
      .count   (count_a),
      .sat     (sat_a)
   );

   ro_edge_counter #(.CNT_W(4)) u_sat (
      .clk     (clk),
      .rst     (rst),
      .start   (start_b),
      .sel_in  (sel_in),
      .window  (window),
      .ro_in   (ro_in),
      .mux_sel (mux_sel_b),
      .busy    (busy_b),
      .done    (done_b),
      .count   (count_b),
      .sat     (sat_b)
   );

   assign t_mux   = cur_b ? mux_sel_b : mux_sel_a;
   assign t_busy  = cur_b ? busy_b : busy_a;
   assign t_done  = cur_b ? done_b : done_a;
   assign t_count = cur_b ? {12'd0, count_b} : count_a;
   assign t_sat   = cur_b ? sat_b : sat_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic measure(input bit use_b, input logic [2:0] sel,
                          input logic [15:0] win, input int half,
                          input int lo, input int hi, input bit esat,
                          input int mid_at, input bit start_on_done,
                          input string nm);
      exp_t        e;
      exp_t        g;
      int          c;
      int          ph;
      bit          got;
      bit          bad_idle;
      logic [15:0] held;
      cur_b = use_b;
      @(negedge clk);
      sel_in = sel;
      window = win;
      if (use_b) start_b = 1'b1;
      else start_a = 1'b1;
      e.lo   = lo;
      e.hi   = hi;
      e.esat = esat;
      e.sel  = sel;
      e.lat  = 1 + SETTLE + int'(win);
      sbq.push_back(e);
      c   = 0;
      ph  = 0;
      got = 1'b0;
      while (!got && c < e.lat + 20) begin
         @(posedge clk);
         c++;
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         if (c == mid_at) begin
            if (use_b) start_b = 1'b1;
            else start_a = 1'b1;
         end
         if (half > 0) begin
            ph++;
            if (ph >= half) begin
               ro_in = ~ro_in;
               ph = 0;
            end
         end
         if (c == 1) begin
            chk++;
            if (t_mux !== sel) begin
               err++;
               $display("FAIL %s mux_sel: got %0d want %0d", nm, t_mux, sel);
            end
            chk++;
            if (t_busy !== 1'b1 || t_count !== 16'd0 || t_sat !== 1'b0) begin
               err++;
               $display("FAIL %s start_state: busy=%b count=%0d sat=%b want 1/0/0",
                        nm, t_busy, t_count, t_sat);
            end
         end
         if (t_done === 1'b1) begin
            got = 1'b1;
            g = sbq.pop_front();
            chk++;
            if (c != g.lat) begin
               err++;
               $display("FAIL %s latency: got %0d want %0d", nm, c, g.lat);
            end
            chk++;
            if (int'(t_count) < g.lo || int'(t_count) > g.hi) begin
               err++;
               $display("FAIL %s count: got %0d want %0d..%0d", nm, t_count, g.lo, g.hi);
            end
            chk++;
            if (t_sat !== g.esat || t_busy !== 1'b0) begin
               err++;
               $display("FAIL %s sat/busy: got %b/%b want %b/0", nm, t_sat, t_busy, g.esat);
            end
            if (start_on_done) begin
               if (use_b) start_b = 1'b1;
               else start_a = 1'b1;
            end
         end
      end
      if (!got) begin
         chk++;
         err++;
         $display("FAIL %s timeout: no done within %0d cycles, want %0d", nm, c, e.lat);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end
      held     = t_count;
      bad_idle = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         if (t_done !== 1'b0 || t_busy !== 1'b0) bad_idle = 1'b1;
      end
      chk++;
      if (bad_idle) begin
         err++;
         $display("FAIL %s after_done: got busy/done activity want idle", nm);
      end
      chk++;
      if (t_count !== held || t_mux !== sel) begin
         err++;
         $display("FAIL %s hold: got count=%0d mux=%0d want %0d/%0d",
                  nm, t_count, t_mux, held, sel);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk++;
      if (mux_sel_a !== 3'd0) begin
         err++;
         $display("FAIL reset mux_sel: got %0d want 0", mux_sel_a);
      end
      chk++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         err++;
         $display("FAIL reset busy/done: got %b/%b want 0/0", busy_a, done_a);
      end
      chk++;
      if (count_a !== 16'd0 || sat_a !== 1'b0) begin
         err++;
         $display("FAIL reset count/sat: got %0d/%b want 0/0", count_a, sat_a);
      end
      chk++;
      if (count_b !== 4'd0 || sat_b !== 1'b0 || busy_b !== 1'b0) begin
         err++;
         $display("FAIL reset small: got count=%0d sat=%b busy=%b want 0/0/0",
                  count_b, sat_b, busy_b);
      end
   endtask

   task automatic test_basic();
      measure(1'b0, 3'd5, 16'd100, 5, 9, 11, 1'b0, -1, 1'b0, "basic");
   endtask

   task automatic test_window_zero();
      measure(1'b0, 3'd3, 16'd0, 5, 0, 0, 1'b0, -1, 1'b0, "win0");
   endtask

   task automatic test_fast();
      measure(1'b0, 3'd7, 16'd20, 1, 9, 11, 1'b0, -1, 1'b0, "fast");
   endtask

   task automatic test_saturation();
      measure(1'b1, 3'd2, 16'd200, 2, 15, 15, 1'b1, -1, 1'b0, "saturate");
      measure(1'b1, 3'd1, 16'd40, 2, 9, 11, 1'b0, -1, 1'b0, "sat_clear");
   endtask

   task automatic test_back_to_back();
      measure(1'b0, 3'd4, 16'd60, 3, 9, 11, 1'b0, 30, 1'b1, "ignored_start");
   endtask

   task automatic test_reset_mid();
      int n_done;
      cur_b = 1'b0;
      @(negedge clk);
      sel_in  = 3'd6;
      window  = 16'd100;
      start_a = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         start_a = 1'b0;
         if (k % 3 == 0) ro_in = ~ro_in;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk++;
      if (mux_sel_a !== 3'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         err++;
         $display("FAIL abort ctrl: got mux=%0d busy=%b done=%b want 0/0/0",
                  mux_sel_a, busy_a, done_a);
      end
      chk++;
      if (count_a !== 16'd0 || sat_a !== 1'b0) begin
         err++;
         $display("FAIL abort count: got %0d/%b want 0/0", count_a, sat_a);
      end
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_a === 1'b1 || busy_a === 1'b1) n_done++;
      end
      chk++;
      if (n_done != 0) begin
         err++;
         $display("FAIL abort no_done: got %0d active cycles want 0", n_done);
      end
      measure(1'b0, 3'd6, 16'd50, 5, 4, 6, 1'b0, -1, 1'b0, "after_abort");
   endtask

   initial begin
      chk     = 0;
      err     = 0;
      cur_b   = 1'b0;
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      sel_in  = 3'd0;
      window  = 16'd0;
      ro_in   = 1'b0;
      test_reset();
      test_basic();
      test_window_zero();
      test_fast();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
